// File: rtl/serial_cmp_seq.sv
// serial_cmp_seq: bit-serial magnitude comparator that walks the operands
// two bits per clock, most significant pair first, and reports lt/gt/eq.
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN ends a compare on the first
// differing pair; without it every compare takes WIDTH/2 RUN cycles.
module serial_cmp_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int unsigned PAIRS = WIDTH / 2;
  localparam int unsigned CW    = $clog2(PAIRS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [CW-1:0]    cnt_q;
  logic             gflag_q;
  logic             lflag_q;
  logic             gflag_d;
  logic             lflag_d;
  logic             finish_d;
  logic             busy_q;
  logic             done_q;
  logic             lt_q;
  logic             gt_q;
  logic             eq_q;
  logic [1:0]       xp;
  logic [1:0]       yp;

  // Cascade update for the current MSB pair and end-of-compare decision.
  // Operands are shifted left each RUN cycle, so the live pair is always the top two bits.
  always_comb begin
    xp       = x_q[WIDTH-1 -: 2];
    yp       = y_q[WIDTH-1 -: 2];
    gflag_d  = ~lflag_q & (gflag_q | (xp > yp));
    lflag_d  = ~gflag_q & (lflag_q | (xp < yp));
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish_d = (cnt_q == CW'(1)) | gflag_d | lflag_d;
`else
    finish_d = (cnt_q == CW'(1));
`endif
  end

  // Control FSM with operand capture, pair counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      gflag_q <= 1'b0;
      lflag_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= x;
            y_q     <= y;
            gflag_q <= 1'b0;
            lflag_q <= 1'b0;
            cnt_q   <= CW'(PAIRS);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q     <= x_q << 2;
          y_q     <= y_q << 2;
          gflag_q <= gflag_d;
          lflag_q <= lflag_d;
          cnt_q   <= cnt_q - CW'(1);
          if (finish_d) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            gt_q    <= gflag_d;
            lt_q    <= lflag_d;
            eq_q    <= ~(gflag_d | lflag_d);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_serial_cmp_seq.sv
// Directed self-checking bench for serial_cmp_seq at WIDTH=8.
// Expected latencies follow SERIAL_CMP_EARLY_EXIT_EN when it is defined.
module tb_serial_cmp_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x     = '0;
  logic [7:0] y     = '0;
  logic       busy;
  logic       done;
  logic       lt;
  logic       gt;
  logic       eq;

  int checks   = 0;
  int failures = 0;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  serial_cmp_seq #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .x    (x),
    .y    (y),
    .busy (busy),
    .done (done),
    .lt   (lt),
    .gt   (gt),
    .eq   (eq)
  );

  always #5 clk = ~clk;

  // Pulse start with the given operands, scramble the inputs after the accept
  // edge, and count edges until done appears (lat = -1 on timeout).
  task automatic do_cmp(input logic [7:0] xa, input logic [7:0] ya,
                        output int lat, output int overlap);
    x = xa; y = ya; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = ~xa; y = ~ya;
    lat = -1; overlap = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (busy && done) overlap = 1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({lt, gt, eq} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {lt, gt, eq}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_equal();
    int lat, ov;
    do_cmp(8'hA5, 8'hA5, lat, ov);
    checks++; if (lat !== 4) begin failures++; $display("FAIL eq_latency got=%0d exp=4", lat); end
    checks++; if ({lt, gt, eq} !== 3'b001) begin failures++; $display("FAIL eq_result got=%b exp=001", {lt, gt, eq}); end
    checks++; if (ov !== 0) begin failures++; $display("FAIL eq_busy_done_overlap got=%0d exp=0", ov); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({lt, gt, eq, busy} !== 4'b0010) begin failures++; $display("FAIL eq_hold got=%b exp=0010", {lt, gt, eq, busy}); end
    do_cmp(8'h00, 8'h00, lat, ov);
    checks++; if (lat !== 4 || {lt, gt, eq} !== 3'b001) begin failures++; $display("FAIL zero_eq got lat=%0d ltgteq=%b exp lat=4 ltgteq=001", lat, {lt, gt, eq}); end
  endtask

  task automatic test_gt();
    int lat, ov;
    int exp_lat;
    exp_lat = EE ? 1 : 4;
    do_cmp(8'h80, 8'h7F, lat, ov);
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL gt_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if ({lt, gt, eq} !== 3'b010) begin failures++; $display("FAIL gt_result got=%b exp=010", {lt, gt, eq}); end
    do_cmp(8'h00, 8'hFF, lat, ov);
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL lt_msb_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if ({lt, gt, eq} !== 3'b100) begin failures++; $display("FAIL lt_msb_result got=%b exp=100", {lt, gt, eq}); end
  endtask

  task automatic test_lt();
    int lat, ov;
    do_cmp(8'h12, 8'h13, lat, ov);
    checks++; if (lat !== 4) begin failures++; $display("FAIL lt_latency got=%0d exp=4", lat); end
    checks++; if ({lt, gt, eq} !== 3'b100) begin failures++; $display("FAIL lt_result got=%b exp=100", {lt, gt, eq}); end
  endtask

  task automatic test_ignore_start();
    int ndone, lat, exp_lat;
    exp_lat = EE ? 2 : 4;
    x = 8'h10; y = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    x = 8'hFF; y = 8'h00;
    ndone = 0; lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 2) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_start_done_count got=%0d exp=1", ndone); end
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL ignore_start_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if ({lt, gt, eq} !== 3'b100) begin failures++; $display("FAIL ignore_start_result got=%b exp=100", {lt, gt, eq}); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, exp_lat2;
    exp_lat2 = EE ? 3 : 4;
    x = 8'h01; y = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    lat1 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat1 = i; break; end
    end
    checks++; if (lat1 !== 4 || {lt, gt, eq} !== 3'b100) begin failures++; $display("FAIL b2b_first got lat=%0d ltgteq=%b exp lat=4 ltgteq=100", lat1, {lt, gt, eq}); end
    x = 8'h05; y = 8'h03;
    @(posedge clk); #1;
    start = 1'b0; x = 8'h00; y = 8'hFF;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    lat2 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = i; break; end
    end
    checks++; if (lat2 !== exp_lat2) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat2, exp_lat2); end
    checks++; if ({lt, gt, eq} !== 3'b010) begin failures++; $display("FAIL b2b_second_result got=%b exp=010", {lt, gt, eq}); end
  endtask

  task automatic test_reset_abort();
    int lat, ov, saw_done, exp_lat;
    exp_lat = EE ? 1 : 4;
    x = 8'h12; y = 8'h13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, lt, gt, eq} !== 5'b00000) begin failures++; $display("FAIL abort_clear got=%b exp=00000", {busy, done, lt, gt, eq}); end
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    checks++; if (saw_done !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", saw_done); end
    rst_n = 1'b1;
    do_cmp(8'hA5, 8'h5A, lat, ov);
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL post_reset_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if ({lt, gt, eq} !== 3'b010) begin failures++; $display("FAIL post_reset_result got=%b exp=010", {lt, gt, eq}); end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_gt();
    test_lt();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_cmp_seq.md
SERIAL_CMP_SEQ -- requirements
Module: serial_cmp_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values are even and >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to compare x and y; sampled only in IDLE.
REQ-005 SHALL have port x  input  WIDTH  operand X; captured on the accepting edge.
REQ-006 SHALL have port y  input  WIDTH  operand Y; captured on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports lt, gt, eq  output  1 each  result of the last completed compare (X<Y, X>Y, X==Y).

Function
REQ-010 SHALL implement a two-state FSM: IDLE, RUN.
REQ-011 IDLE with start=1 at an edge (accept edge E0) SHALL capture x and y, clear the internal cascade flags (lflag=0, gflag=0), load pair counter = WIDTH/2, and enter RUN.
REQ-012 In RUN, each edge SHALL process one 2-bit pair of the captured operands, MSB pair first, then decrement the counter.
REQ-013 Per pair (xp, yp) the cascade update SHALL be: gflag <= ~lflag & (gflag | xp>yp); lflag <= ~gflag & (lflag | xp<yp).
REQ-014 Once gflag or lflag is set it SHALL remain set and the other SHALL remain clear for the rest of the compare.
REQ-015 On the edge processing the last pair (E(WIDTH/2)) the FSM SHALL return to IDLE, set done=1, and load gt=gflag_next, lt=lflag_next, eq=~(gflag_next | lflag_next).
REQ-016 done SHALL be high for exactly one cycle, deasserting on the next edge.
REQ-017 Latency: done SHALL be visible in the cycle after edge E(WIDTH/2), i.e. WIDTH/2 edges after the accept edge.
REQ-018 Exactly one of lt, gt, eq SHALL be high after any completion; the three SHALL hold their values until the next completion.
REQ-019 start while in RUN SHALL be ignored, with no effect on captured operands or counter.
REQ-020 start high in the cycle where done=1 (FSM in IDLE) SHALL be accepted; the back-to-back compare proceeds normally.
REQ-021 x and y changes after the accept edge SHALL NOT affect the compare in progress.
REQ-022 busy SHALL be high from the edge after E0 through the edge that completes; done and busy SHALL never be high together.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, busy=0, done=0, lt=0, gt=0, eq=0, cascade flags and counter 0.
REQ-024 Reset asserted mid-RUN SHALL abort the compare with no done pulse; after release the block SHALL accept a new start.
REQ-025 The first edge after rst_n rises SHALL be a legal accept edge.

Configuration
REQ-026 Macro SERIAL_CMP_EARLY_EXIT_EN SHALL control early termination.
REQ-027 With SERIAL_CMP_EARLY_EXIT_EN defined: when a pair sets gflag or lflag, that edge SHALL complete the compare exactly as in REQ-015 (done next cycle, remaining pairs skipped).
REQ-028 Without SERIAL_CMP_EARLY_EXIT_EN: every compare SHALL take exactly WIDTH/2 RUN edges regardless of data.
REQ-029 Equal operands SHALL take WIDTH/2 edges in both configurations.

Verification (WIDTH=8)
REQ-030 x=8'hA5, y=8'hA5, start pulse -> done 4 edges after accept; eq=1, lt=0, gt=0.
REQ-031 x=8'h80, y=8'h7F -> gt=1; done after 4 edges without macro, after 1 edge with SERIAL_CMP_EARLY_EXIT_EN.
REQ-032 x=8'h12, y=8'h13 -> lt=1 after 4 edges in both configurations.
REQ-033 Accept x=8'h10,y=8'h20; drive start with x=8'hFF,y=8'h00 during RUN -> ignored, single done, lt=1.
REQ-034 Start held high through done cycle with new x=8'h05,y=8'h03 -> second compare accepted, second done shows gt=1.
REQ-035 rst_n low 2 edges into a compare -> busy, done, lt, gt, eq all 0 at once; no done pulse; next start completes normally.
